id_ex_elastic_reg: RTL and testbench

//   Parametrised ID->EX pipeline stage register with valid/ready flow control,
//   a 2-entry skid buffer, synchronous flush and bubble insertion. Sits between

---
 rtl/id_ex_elastic_reg_if.sv | 29 ++
 rtl/id_ex_elastic_reg.sv | 116 +++++++++++
 tb/tb_id_ex_elastic_reg.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_elastic_reg_if.sv
// Handshake bundle between decode, the ID->EX elastic register and execute.
// master = the decode/execute environment, slave = the stage register itself.
interface id_ex_elastic_reg_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 11
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_instr;
   logic [WIDTH-1:0]  in_pc;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_instr;
   logic [WIDTH-1:0]  out_pc;
   logic [CTRL_W-1:0] out_ctrl;
   logic [1:0]        occupancy;

   modport master (
      output flush, in_valid, in_instr, in_pc, in_ctrl, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_ctrl, occupancy
   );

   modport slave (
      input  flush, in_valid, in_instr, in_pc, in_ctrl, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_ctrl, occupancy
   );
endinterface

// File: rtl/id_ex_elastic_reg.sv
// ID->EX pipeline register: head + skid entry, valid/ready flow control,
// synchronous flush and combinational bubble gating of the outputs.
module id_ex_elastic_reg #(
   parameter int               WIDTH    = 32,
   parameter int               CTRL_W   = 11,
   parameter logic [WIDTH-1:0] NOP_INSN = WIDTH'(32'h00000013)
) (
   input  logic                clk,
   input  logic                rst_n,
   id_ex_elastic_reg_if.slave  io_bus
);
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [WIDTH-1:0]  r_head_instr, r_head_pc, r_skid_instr, r_skid_pc;
   logic [CTRL_W-1:0] r_head_ctrl, r_skid_ctrl;

   logic w_in_ready, w_out_valid, w_push, w_pop;
   logic w_load_head, w_shift_head, w_load_skid;

   // Handshake signals come from state alone, so out_ready never reaches in_ready.
   always_comb begin
      w_in_ready  = (r_state != S_FULL);
      w_out_valid = (r_state != S_EMPTY);
   end

   assign w_push = io_bus.in_valid & w_in_ready;
   assign w_pop  = w_out_valid & io_bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (io_bus.flush) begin
         w_state_next = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: if (w_push)           w_state_next = S_ONE;
            S_ONE: begin
               if (w_push && !w_pop)       w_state_next = S_FULL;
               else if (!w_push && w_pop)  w_state_next = S_EMPTY;
            end
            S_FULL:  if (w_pop)            w_state_next = S_ONE;
            default:                       w_state_next = S_EMPTY;
         endcase
      end
   end

   // A flushed cycle leaves the data registers alone; their contents are dead anyway.
   always_comb begin
      w_load_head  = 1'b0;
      w_shift_head = 1'b0;
      w_load_skid  = 1'b0;
      if (!io_bus.flush) begin
         case (r_state)
            S_EMPTY: w_load_head = w_push;
            S_ONE: begin
               w_load_head = w_push & w_pop;
               w_load_skid = w_push & ~w_pop;
            end
            S_FULL:  w_shift_head = w_pop;
            default: w_load_head = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head_instr <= NOP_INSN;
         r_head_pc    <= '0;
         r_head_ctrl  <= '0;
      end else if (w_load_head) begin
         r_head_instr <= io_bus.in_instr;
         r_head_pc    <= io_bus.in_pc;
         r_head_ctrl  <= io_bus.in_ctrl;
      end else if (w_shift_head) begin
         r_head_instr <= r_skid_instr;
         r_head_pc    <= r_skid_pc;
         r_head_ctrl  <= r_skid_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_skid_instr <= NOP_INSN;
         r_skid_pc    <= '0;
         r_skid_ctrl  <= '0;
      end else if (w_load_skid) begin
         r_skid_instr <= io_bus.in_instr;
         r_skid_pc    <= io_bus.in_pc;
         r_skid_ctrl  <= io_bus.in_ctrl;
      end
   end

   // Dead slots present a NOP with zero control so RegWrite/MemWrite cannot leak.
   always_comb begin
      io_bus.in_ready  = w_in_ready;
      io_bus.out_valid = w_out_valid;
      io_bus.occupancy = r_state;
      io_bus.out_instr = w_out_valid ? r_head_instr : NOP_INSN;
      io_bus.out_pc    = w_out_valid ? r_head_pc    : '0;
      io_bus.out_ctrl  = w_out_valid ? r_head_ctrl  : '0;
   end
endmodule

// File: tb/tb_id_ex_elastic_reg.sv
// Self-checking bench: directed scenarios plus random traffic, scored against
// a two-entry FIFO model kept as a queue.
module tb_id_ex_elastic_reg;
   localparam int          WIDTH  = 32;
   localparam int          CTRL_W = 11;
   localparam logic [31:0] NOP    = 32'h00000013;

   typedef struct {
      logic [WIDTH-1:0]  instr;
      logic [WIDTH-1:0]  pc;
      logic [CTRL_W-1:0] ctrl;
   } ent_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   ent_t exp_q[$];

   id_ex_elastic_reg_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) bus ();

   id_ex_elastic_reg #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .NOP_INSN(NOP)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of capacity two, updated on every clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         bit   can_push;
         ent_t e;
         can_push = (exp_q.size() != 2);
         if (bus.flush) begin
            exp_q.delete();
         end else begin
            if (bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (bus.in_valid && can_push) begin
               e.instr = bus.in_instr;
               e.pc    = bus.in_pc;
               e.ctrl  = bus.in_ctrl;
               exp_q.push_back(e);
            end
         end
      end
   end

   // Monitor: compare the presented head (or bubble) with the model every cycle.
   always @(negedge clk) begin
      chk("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      chk("in_ready",  64'(bus.in_ready),  64'(exp_q.size() != 2));
      if (exp_q.size() != 0) begin
         chk("head_instr", 64'(bus.out_instr), 64'(exp_q[0].instr));
         chk("head_pc",    64'(bus.out_pc),    64'(exp_q[0].pc));
         chk("head_ctrl",  64'(bus.out_ctrl),  64'(exp_q[0].ctrl));
         if (bus.out_ready)
            $display("pop  pc=0x%08h instr=0x%08h ctrl=0x%03h", bus.out_pc, bus.out_instr, bus.out_ctrl);
      end else begin
         chk("bubble_instr", 64'(bus.out_instr), 64'(NOP));
         chk("bubble_pc",    64'(bus.out_pc),    64'd0);
         chk("bubble_ctrl",  64'(bus.out_ctrl),  64'd0);
      end
   end

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      bus.in_valid  = v;
      bus.in_instr  = instr;
      bus.in_pc     = pc;
      bus.in_ctrl   = CTRL_W'($urandom);
      bus.out_ready = ordy;
      bus.flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
      chk({tag, "_occupancy"}, 64'(bus.occupancy), 64'd0);
      chk({tag, "_out_ctrl"},  64'(bus.out_ctrl),  64'd0);
      chk({tag, "_out_instr"}, 64'(bus.out_instr), 64'(NOP));
      chk({tag, "_out_pc"},    64'(bus.out_pc),    64'd0);
   endtask

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
      bus.in_ctrl = '0; bus.out_ready = 1'b0;
      #1 rst_n = 1'b0;

      // T1: reset held while decode presents an entry
      bus.in_valid = 1'b1; bus.in_instr = 32'h00500093; bus.in_ctrl = '1;
      repeat (3) @(posedge clk);
      #2;
      chk_reset_outputs("t1_rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t1_latency_instr", 64'(bus.out_instr), 64'h00500093);
      drive(0, 0, 0, 1, 0);

      // T2: streaming
      drive(1, $urandom, 32'h0, 1, 0);
      drive(1, $urandom, 32'h4, 1, 0);
      drive(1, $urandom, 32'h8, 1, 0);
      drive(0, 0, 0, 1, 0);

      // T3: backpressure, C refused while full, then drained in order
      drive(1, $urandom, 32'h10, 0, 0);
      drive(1, $urandom, 32'h14, 0, 0);
      drive(1, 32'hC, 32'h18, 0, 0);
      chk("t3_full_in_ready", 64'(bus.in_ready), 64'd0);
      drive(1, 32'hC, 32'h18, 1, 0);
      drive(1, 32'hC, 32'h18, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);

      // T4: flush while full with a same-cycle push
      drive(1, $urandom, 32'h20, 0, 0);
      drive(1, $urandom, 32'h24, 0, 0);
      drive(1, 32'hD, 32'h28, 1, 1);
      chk("t4_flush_occ", 64'(bus.occupancy), 64'd0);
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);

      // T5: bubble inside a stream
      drive(1, $urandom, 32'h30, 1, 0);
      drive(0, 0, 0, 1, 0);
      drive(1, $urandom, 32'h34, 1, 0);
      drive(0, 0, 0, 1, 0);

      // T6: asynchronous reset while full
      drive(1, $urandom, 32'h40, 0, 0);
      drive(1, $urandom, 32'h44, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6_rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive(1, 32'h00A00113, 32'h50, 1, 0);
      chk("t6_latency_pc", 64'(bus.out_pc), 64'h50);
      drive(0, 0, 0, 1, 0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 9) < 7), $urandom, {$urandom_range(0, 1023), 2'b00},
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      end
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 1, 0);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
